muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_step.sv | 58 +++++
 rtl/muldiv_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the multi-cycle multiply/divide sequencer:
//   - operation encodings carried on Op_in
//   - sequencer state enum
//   - iteration count and datapath word width
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int WORD_W     = 32;
    localparam int ITER_COUNT = 32;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage : muldiv_pkg

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One combinational iteration of the shared multiply/divide datapath.
//   is_div   : 0 = shift-add multiply step, 1 = restoring shift-subtract step
//   acc_hi   : multiply -> running upper product half; divide -> partial remainder
//   acc_lo   : multiply -> multiplier bits (LSB consumed first);
//              divide   -> dividend bits shifting out / quotient bits shifting in
//   operand  : multiply -> multiplicand magnitude; divide -> divisor magnitude
//   next_hi  : acc_hi after this iteration
//   next_lo  : acc_lo after this iteration
// -----------------------------------------------------------------------------
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic              is_div,
    input  logic [WORD_W-1:0] acc_hi,
    input  logic [WORD_W-1:0] acc_lo,
    input  logic [WORD_W-1:0] operand,
    output logic [WORD_W-1:0] next_hi,
    output logic [WORD_W-1:0] next_lo
);

    logic [WORD_W:0] sum;
    logic [WORD_W:0] shifted;
    logic [WORD_W:0] diff;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the branches below can leave one unassigned
        // (which would infer a latch).
        next_hi = acc_hi;
        next_lo = acc_lo;

        // Multiply: add the multiplicand when the current multiplier bit is set,
        // then shift the 65-bit {carry, hi, lo} right by one.
        sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);

        // Divide: bring the next dividend bit into the remainder and try the
        // subtraction. Since the remainder stays below the divisor, a clear
        // borrow bit means the difference fits back into WORD_W bits.
        shifted = {acc_hi, acc_lo[WORD_W-1]};
        diff    = shifted - {1'b0, operand};

        if (is_div) begin
            if (!diff[WORD_W]) begin
                next_hi = diff[WORD_W-1:0];
                next_lo = {acc_lo[WORD_W-2:0], 1'b1};
            end else begin
                next_hi = shifted[WORD_W-1:0];
                next_lo = {acc_lo[WORD_W-2:0], 1'b0};
            end
        end else begin
            next_hi = sum[WORD_W:1];
            next_lo = {sum[0], acc_lo[WORD_W-1:1]};
        end
    end

endmodule : muldiv_step

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Multi-cycle MIPS-style HI/LO multiply/divide unit: 32 shift-add or restoring
// shift-subtract iterations followed by one sign-fix/write cycle.
//
// Build option: define MULDIV_SIGNED_EN to make MULT/DIV signed. Without it,
// MULT/DIV behave exactly as MULTU/DIVU and no sign logic is built.
//
// Ports:
//   Clk          : clock, all state on rising edge
//   Reset        : synchronous active-high reset
//   Start_in     : request a new operation (accepted only in IDLE)
//   Op_in        : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU
//   A_in, B_in   : operands, captured at acceptance
//   HiLoRead_in  : decode stage holds MFHI/MFLO
//   Hi_out/Lo_out: HI/LO registers, written only in FIX
//   Busy_out     : operation in flight
//   Done_out     : one-cycle pulse after HI/LO take a new result
//   DivZero_out  : pulses with Done_out when a divide had B = 0
//   Stall_out    : HiLoRead_in AND Busy_out (combinational)
// -----------------------------------------------------------------------------
module muldiv_sequencer
    import muldiv_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start_in,
    input  logic [1:0]        Op_in,
    input  logic [WORD_W-1:0] A_in,
    input  logic [WORD_W-1:0] B_in,
    input  logic              HiLoRead_in,
    output logic [WORD_W-1:0] Hi_out,
    output logic [WORD_W-1:0] Lo_out,
    output logic              Busy_out,
    output logic              Done_out,
    output logic              DivZero_out,
    output logic              Stall_out
);

    state_t            state;
    logic [5:0]        count;
    logic              is_div;
    logic              div_zero;
    logic [WORD_W-1:0] acc_hi;
    logic [WORD_W-1:0] acc_lo;
    logic [WORD_W-1:0] operand;

    logic [WORD_W-1:0] a_mag;
    logic [WORD_W-1:0] b_mag;
    logic [WORD_W-1:0] step_hi;
    logic [WORD_W-1:0] step_lo;
    logic [WORD_W-1:0] fix_hi;
    logic [WORD_W-1:0] fix_lo;

`ifdef MULDIV_SIGNED_EN
    logic              signed_op;
    logic              a_neg;
    logic              b_neg;
    logic              neg_main;    // negate product / quotient
    logic              neg_rem;     // remainder follows dividend sign
    logic [2*WORD_W-1:0] product;
`endif

    assign Stall_out = HiLoRead_in & Busy_out;

    // Operand magnitudes fed to the unsigned iteration datapath.
    always_comb begin
`ifdef MULDIV_SIGNED_EN
        signed_op = (Op_in == OP_MULT) || (Op_in == OP_DIV);
        a_neg     = signed_op & A_in[WORD_W-1];
        b_neg     = signed_op & B_in[WORD_W-1];
        a_mag     = a_neg ? -A_in : A_in;
        b_mag     = b_neg ? -B_in : B_in;
`else
        a_mag     = A_in;
        b_mag     = B_in;
`endif
    end

    muldiv_step u_step (
        .is_div  (is_div),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .operand (operand),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    // Result as written in FIX. The accumulator already holds {hi, lo} in the
    // architectural placement for both multiply and divide, so only the sign
    // correction differs. A divide-by-zero result is preloaded and bypasses it.
    always_comb begin
        fix_hi = acc_hi;
        fix_lo = acc_lo;
`ifdef MULDIV_SIGNED_EN
        product = {acc_hi, acc_lo};
        if (!div_zero) begin
            if (is_div) begin
                if (neg_main) fix_lo = -acc_lo;
                if (neg_rem)  fix_hi = -acc_hi;
            end else if (neg_main) begin
                product = -product;
                fix_hi  = product[2*WORD_W-1:WORD_W];
                fix_lo  = product[WORD_W-1:0];
            end
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            // The working registers (acc_*, operand, flags) are always loaded
            // at acceptance before being read, so they carry no reset.
            state       <= IDLE;
            count       <= '0;
            Hi_out      <= '0;
            Lo_out      <= '0;
            Busy_out    <= 1'b0;
            Done_out    <= 1'b0;
            DivZero_out <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            Done_out    <= 1'b0;
            DivZero_out <= 1'b0;

            case (state)
                IDLE: begin
                    if (Start_in) begin
                        Busy_out <= 1'b1;
                        count    <= 6'(ITER_COUNT);
                        is_div   <= op_is_div(Op_in);
`ifdef MULDIV_SIGNED_EN
                        neg_main <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
`endif
                        if (op_is_div(Op_in) && (B_in == '0)) begin
                            // Skip iteration; FIX writes Hi = A, Lo = all ones.
                            div_zero <= 1'b1;
                            acc_hi   <= A_in;
                            acc_lo   <= '1;
                            operand  <= '0;
                            state    <= FIX;
                        end else if (op_is_div(Op_in)) begin
                            div_zero <= 1'b0;
                            acc_hi   <= '0;
                            acc_lo   <= a_mag;
                            operand  <= b_mag;
                            state    <= DIV;
                        end else begin
                            div_zero <= 1'b0;
                            acc_hi   <= '0;
                            acc_lo   <= b_mag;
                            operand  <= a_mag;
                            state    <= MUL;
                        end
                    end
                end

                MUL, DIV: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    count  <= count - 6'd1;
                    if (count == 6'd1) begin
                        state <= FIX;
                    end
                end

                FIX: begin
                    Hi_out      <= fix_hi;
                    Lo_out      <= fix_lo;
                    Done_out    <= 1'b1;
                    DivZero_out <= div_zero;
                    Busy_out    <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule : muldiv_sequencer

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Self-checking bench for muldiv_sequencer: directed vector table, randomized
// operations against an arithmetic reference model, and hand-written sequences
// for ignored starts, stalls, back-to-back starts and reset behaviour.
// Expected values follow the MULDIV_SIGNED_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

`ifdef MULDIV_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic        Clk;
    logic        Reset;
    logic        Start_in;
    logic [1:0]  Op_in;
    logic [31:0] A_in;
    logic [31:0] B_in;
    logic        HiLoRead_in;
    logic [31:0] Hi_out;
    logic [31:0] Lo_out;
    logic        Busy_out;
    logic        Done_out;
    logic        DivZero_out;
    logic        Stall_out;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_sequencer dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start_in    (Start_in),
        .Op_in       (Op_in),
        .A_in        (A_in),
        .B_in        (B_in),
        .HiLoRead_in (HiLoRead_in),
        .Hi_out      (Hi_out),
        .Lo_out      (Lo_out),
        .Busy_out    (Busy_out),
        .Done_out    (Done_out),
        .DivZero_out (DivZero_out),
        .Stall_out   (Stall_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          busy;
    } vec_t;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural definition.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        logic        sgn_op;
        logic [63:0] p;
        longint      sa;
        longint      sb;
        sgn_op = SGN && (op == 2'd0 || op == 2'd2);
        dz     = 1'b0;
        if (op < 2'd2) begin
            if (sgn_op) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = sa * sb;
            end else begin
                p = {32'b0, a} * {32'b0, b};
            end
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
            dz = 1'b1;
        end else if (sgn_op) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                lo = 32'h8000_0000;
                hi = 32'd0;
            end else begin
                lo = $signed(a) / $signed(b);
                hi = $signed(a) % $signed(b);
            end
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    // Drive a start request at the current (negedge) time.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        Start_in = 1'b1;
        Op_in    = op;
        A_in     = a;
        B_in     = b;
    endtask

    // Pass the accepting edge, then count cycles with Busy_out high (bounded).
    // Returns at the first negedge with Busy_out low, i.e. the Done_out cycle.
    task automatic wait_done(output int busy_cycles);
        @(negedge Clk);
        Start_in    = 1'b0;
        busy_cycles = 0;
        while (Busy_out && busy_cycles < 100) begin
            busy_cycles++;
            @(negedge Clk);
        end
    endtask

    task automatic run_and_check(input string name, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp_hi,
                                 input logic [31:0] exp_lo, input logic exp_dz, input int exp_busy);
        int cycles;
        @(negedge Clk);
        start_op(op, a, b);
        wait_done(cycles);
        check({name, " busy"},   64'(cycles),      64'(exp_busy));
        check({name, " done"},   64'(Done_out),    64'd1);
        check({name, " dz"},     64'(DivZero_out), 64'(exp_dz));
        check({name, " hi:lo"},  {Hi_out, Lo_out}, {exp_hi, exp_lo});
    endtask

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          cycles;
        int          done_cnt;
        logic [31:0] m_hi;
        logic [31:0] m_lo;
        logic        m_dz;
        logic [31:0] keep_hi;
        logic [31:0] keep_lo;
        logic [1:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;

        vecs[0] = '{2'd0, 32'd7,          32'hFFFF_FFFD, SGN ? 32'hFFFF_FFFF : 32'h6,          32'hFFFF_FFEB, 1'b0, 33};
        vecs[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE,                       32'h0000_0001, 1'b0, 33};
        vecs[2] = '{2'd2, 32'hFFFF_FFF9, 32'd2,         SGN ? 32'hFFFF_FFFF : 32'h1,          SGN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC, 1'b0, 33};
        vecs[3] = '{2'd3, 32'd100,       32'd0,         32'd100,                              32'hFFFF_FFFF, 1'b1, 1};
        vecs[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, SGN ? 32'h0 : 32'h8000_0000,          SGN ? 32'h8000_0000 : 32'h0, 1'b0, 33};
        vecs[5] = '{2'd2, 32'd5,         32'd0,         32'd5,                                32'hFFFF_FFFF, 1'b1, 1};
        vecs[6] = '{2'd3, 32'hFFFF_FFFF, 32'd1,         32'd0,                                32'hFFFF_FFFF, 1'b0, 33};
        vecs[7] = '{2'd1, 32'd0,         32'd12345,     32'd0,                                32'd0,         1'b0, 33};
        vecs[8] = '{2'd2, 32'd7,         32'hFFFF_FFFE, SGN ? 32'd1 : 32'd7,                  SGN ? 32'hFFFF_FFFD : 32'd0, 1'b0, 33};
        vecs[9] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000,                       32'd0,         1'b0, 33};

        Reset       = 1'b1;
        Start_in    = 1'b0;
        Op_in       = 2'd0;
        A_in        = 32'd0;
        B_in        = 32'd0;
        HiLoRead_in = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        check("reset hi",   64'(Hi_out),      64'd0);
        check("reset lo",   64'(Lo_out),      64'd0);
        check("reset busy", 64'(Busy_out),    64'd0);
        check("reset done", 64'(Done_out),    64'd0);
        check("reset dz",   64'(DivZero_out), 64'd0);
        HiLoRead_in = 1'b1;
        #1;
        check("idle stall", 64'(Stall_out), 64'd0);
        HiLoRead_in = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                          vecs[i].hi, vecs[i].lo, vecs[i].dz, vecs[i].busy);
        end

        // Done is a single pulse and HI/LO hold afterwards.
        keep_hi = Hi_out;
        keep_lo = Lo_out;
        repeat (3) @(negedge Clk);
        check("done pulse width", 64'(Done_out), 64'd0);
        check("hold hi:lo", {Hi_out, Lo_out}, {keep_hi, keep_lo});

        // Back-to-back: start again in the Done cycle.
        @(negedge Clk);
        start_op(2'd1, 32'd6, 32'd9);
        wait_done(cycles);
        check("b2b first done", 64'(Done_out), 64'd1);
        start_op(2'd3, 32'd50, 32'd7);
        wait_done(cycles);
        check("b2b second busy", 64'(cycles), 64'd33);
        check("b2b second hi:lo", {Hi_out, Lo_out}, {32'd1, 32'd7});

        // Ignored start at cycle 5, MFHI stall at cycle 10, exactly one Done.
        @(negedge Clk);
        start_op(2'd3, 32'd1000, 32'd7);
        @(negedge Clk);
        Start_in = 1'b0;
        done_cnt = 0;
        for (int i = 1; i <= 60; i++) begin
            if (i == 5) start_op(2'd1, 32'hFFFF_FFFF, 32'd3);
            if (i == 6) Start_in = 1'b0;
            if (i == 10) begin
                HiLoRead_in = 1'b1;
                #1;
                check("stall at cycle 10", 64'(Stall_out), 64'd1);
                HiLoRead_in = 1'b0;
            end
            if (Done_out) done_cnt++;
            @(negedge Clk);
        end
        check("ignored start done count", 64'(done_cnt), 64'd1);
        check("ignored start hi:lo", {Hi_out, Lo_out}, {32'd6, 32'd142});
        check("ignored start idle", 64'(Busy_out), 64'd0);

        // Reset mid-operation abandons the MULT.
        start_op(2'd0, 32'd123, 32'd456);
        @(negedge Clk);
        Start_in = 1'b0;
        for (int i = 1; i < 12; i++) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("mid reset busy", 64'(Busy_out), 64'd0);
        check("mid reset hi:lo", {Hi_out, Lo_out}, 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done_out || Busy_out) done_cnt++;
            @(negedge Clk);
        end
        check("mid reset no done", 64'(done_cnt), 64'd0);
        check("mid reset hold", {Hi_out, Lo_out}, 64'd0);

        // Reset wins over Start_in in the same cycle.
        start_op(2'd1, 32'd3, 32'd3);
        Reset = 1'b1;
        @(negedge Clk);
        Reset    = 1'b0;
        Start_in = 1'b0;
        check("reset priority busy", 64'(Busy_out), 64'd0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            case ($urandom_range(0, 7))
                0:       r_b = 32'd0;
                1:       r_b = 32'($urandom_range(1, 15));
                2:       r_b = 32'hFFFF_FFFF;
                default: r_b = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) r_a = 32'h8000_0000;
            model(r_op, r_a, r_b, m_hi, m_lo, m_dz);
            run_and_check($sformatf("rand%0d op%0d a=%h b=%h", i, r_op, r_a, r_b),
                          r_op, r_a, r_b, m_hi, m_lo, m_dz,
                          (r_op[1] && r_b == 32'd0) ? 1 : 33);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_muldiv_sequencer
